// File: rtl/excl_grant_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : excl_grant_arbiter
//  Purpose  : Two-requester round-robin arbiter. Grants o_gnt_a / o_gnt_b are
//             registered and never high together. The arbiter bounds how long
//             one owner can keep the grant while the other side waits. It
//             alternates fairly under contention. It also inserts a fixed
//             all-low turnaround gap between any two grants.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    MAX_HOLD    grant cycles before the owner is preempted while the other
//                side is requesting (>= 1)
//    TURNAROUND  cycles with both grants low between two grants (1..15)
//  Ports
//    clk         single clock, all state updates on the rising edge
//    rst         synchronous active-high reset
//    i_req_a     requester A wants the resource (level)
//    i_req_b     requester B wants the resource (level)
//    i_done_a    A releases; only looked at while A owns the grant
//    i_done_b    B releases; only looked at while B owns the grant
//    o_gnt_a     grant to A (registered)
//    o_gnt_b     grant to B (registered)
//    o_preempt   one-cycle pulse: owner removed purely by hold-limit expiry
//    o_hold_cnt  cycles the current owner has held the grant, saturating at
//                MAX_HOLD; zero while nobody owns the resource
// ============================================================================
module excl_grant_arbiter #(
   parameter int MAX_HOLD   = 8,
   parameter int TURNAROUND = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_req_a,
   input  logic                          i_req_b,
   input  logic                          i_done_a,
   input  logic                          i_done_b,
   output logic                          o_gnt_a,
   output logic                          o_gnt_b,
   output logic                          o_preempt,
   output logic [$clog2(MAX_HOLD+1)-1:0] o_hold_cnt
);

   localparam int HW = $clog2(MAX_HOLD + 1);

   localparam logic [HW-1:0] c_MAX_HOLD = HW'(MAX_HOLD);
   localparam logic [HW-1:0] c_HOLD_ONE = HW'(1);

   // The gap counter is loaded with TURNAROUND-1 on release. The cycle that
   // directly follows a release is always low, so that cycle supplies the
   // first gap cycle without any counting.
   localparam int             c_GAP_W    = 4;
   localparam logic [c_GAP_W-1:0] c_GAP_INIT = c_GAP_W'(TURNAROUND - 1);
   localparam logic [c_GAP_W-1:0] c_GAP_ONE  = c_GAP_W'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_OWN_A = 2'd1,
      S_OWN_B = 2'd2
   } state_t;

   state_t               r_state;
   logic                 r_gnt_a;
   logic                 r_gnt_b;
   logic                 r_preempt;
   logic [HW-1:0]        r_hold;
   logic [c_GAP_W-1:0]   r_gap;
   logic                 r_last_b;   // 1: B was the most recent owner

   // ------------------------------------------------------------------------
   // Release decode for the current owner. The hold limit releases only when
   // the other side is actually waiting. Without contention, the owner keeps
   // the grant indefinitely.
   // ------------------------------------------------------------------------
   logic w_at_max;
   logic w_expire_a;
   logic w_expire_b;
   logic w_rel_a;
   logic w_rel_b;
   logic w_pre_a;
   logic w_pre_b;

   assign w_at_max   = (r_hold == c_MAX_HOLD);
   assign w_expire_a = w_at_max & i_req_b;
   assign w_expire_b = w_at_max & i_req_a;

   assign w_rel_a = i_done_a | ~i_req_a | w_expire_a;
   assign w_rel_b = i_done_b | ~i_req_b | w_expire_b;

   // Preempt is reported only when expiry is the sole reason for release.
   // A coincident done or request drop counts as a normal release.
   assign w_pre_a = w_expire_a & i_req_a & ~i_done_a;
   assign w_pre_b = w_expire_b & i_req_b & ~i_done_b;

   // Tie-break: on contention the side that did not own last wins.
   logic w_pick_a;
   logic w_pick_b;

   assign w_pick_a = i_req_a & (~i_req_b | r_last_b);
   assign w_pick_b = i_req_b & ~w_pick_a;

   // ------------------------------------------------------------------------
   // Arbitration FSM; every output is a register written here.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_gnt_a   <= 1'b0;
         r_gnt_b   <= 1'b0;
         r_preempt <= 1'b0;
         r_hold    <= '0;
         r_gap     <= '0;
         r_last_b  <= 1'b1;
      end else begin
         r_preempt <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (r_gap != '0) begin
                  r_gap <= r_gap - c_GAP_ONE;
               end else if (w_pick_a) begin
                  r_state <= S_OWN_A;
                  r_gnt_a <= 1'b1;
                  r_hold  <= c_HOLD_ONE;
               end else if (w_pick_b) begin
                  r_state <= S_OWN_B;
                  r_gnt_b <= 1'b1;
                  r_hold  <= c_HOLD_ONE;
               end
            end

            S_OWN_A: begin
               if (w_rel_a) begin
                  r_state   <= S_IDLE;
                  r_gnt_a   <= 1'b0;
                  r_hold    <= '0;
                  r_gap     <= c_GAP_INIT;
                  r_last_b  <= 1'b0;
                  r_preempt <= w_pre_a;
               end else if (!w_at_max) begin
                  r_hold <= r_hold + c_HOLD_ONE;
               end
            end

            S_OWN_B: begin
               if (w_rel_b) begin
                  r_state   <= S_IDLE;
                  r_gnt_b   <= 1'b0;
                  r_hold    <= '0;
                  r_gap     <= c_GAP_INIT;
                  r_last_b  <= 1'b1;
                  r_preempt <= w_pre_b;
               end else if (!w_at_max) begin
                  r_hold <= r_hold + c_HOLD_ONE;
               end
            end

            default: begin
               // Unreachable encoding: drop both grants and re-arbitrate.
               r_state <= S_IDLE;
               r_gnt_a <= 1'b0;
               r_gnt_b <= 1'b0;
               r_hold  <= '0;
               r_gap   <= '0;
            end
         endcase
      end
   end

   assign o_gnt_a    = r_gnt_a;
   assign o_gnt_b    = r_gnt_b;
   assign o_preempt  = r_preempt;
   assign o_hold_cnt = r_hold;

endmodule
`default_nettype wire
